instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- IF stage of the 5-stage MIPS pipeline.
- Holds the PC and a loadable instruction memory, and drives the IF/ID pipeline register that feeds the decode stage.
- Takes stall, flush and jump/branch redirect from the hazard and decode logic.
- Provides a word-write port so the debug/loader unit can fill program memory before execution.

Parameters:
- SIZE, 32, data/instruction/PC width in bits.
- MEM_DEPTH, 64, instruction memory depth in words.
- SIZE_ADDR, $clog2(MEM_DEPTH), word-index width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- i_stall  input  1  hold PC and IF/ID register.
- i_flush  input  1  load a bubble (NOP) into IF/ID.
- i_jump  input  1  redirect PC to i_jump_addr.
- i_jump_addr  input  SIZE  redirect target, byte address.
- i_load_en  input  1  write i_load_data into instruction memory.
- i_load_addr  input  SIZE_ADDR  word index for load.
- i_load_data  input  SIZE  instruction word to load.
- o_instruction  output  SIZE  IF/ID instruction register.
- o_pc_plus4  output  SIZE  IF/ID copy of fetch PC+4.
- o_pc  output  SIZE  current PC (byte address).
- o_valid  output  1  IF/ID holds a real fetched instruction (0 = bubble).
- o_halted  output  1  program halted (see Optional Feature).

Behaviour:
- Reset: clock and reset as stated in Ports.
  - On rst at an edge: PC=0, o_instruction=0x00000000 (NOP), o_pc_plus4=0, o_valid=0, o_halted=0.
  - Memory contents are not cleared by rst.
  - rst overrides every other input, including mid-load and mid-stall.
- Fetch:
  - Memory read is asynchronous at word index PC[SIZE_ADDR+1:2]; PC[1:0] and bits above SIZE_ADDR+1 are ignored.
  - The index therefore wraps modulo MEM_DEPTH.
  - Fetched word registers into o_instruction at the edge, so latency PC -> o_instruction is 1 cycle.
- PC arithmetic: PC+4 is computed modulo 2^SIZE; o_pc_plus4 is registered with its instruction.
- Priority at each edge: rst > i_load_en > i_stall > i_jump/i_flush > normal.
  - i_load_en=1: memory[i_load_addr] <= i_load_data. PC and IF/ID hold.
  - i_stall=1: PC and IF/ID hold. i_jump and i_flush are ignored; decode re-asserts them after the stall releases.
  - i_jump=1: PC <= {i_jump_addr[SIZE-1:2],2'b00}. Low two bits are forced to zero.
  - i_flush=1: IF/ID <= {NOP, pc_plus4=0, valid=0}.
  - i_jump=1 and i_flush=0: the currently fetched word (delay slot) registers normally with valid=1.
  - Taken branch without delay slot: decode asserts i_jump and i_flush together.
  - Normal: PC <= PC+4. IF/ID <= {mem[PC], PC+4, 1}.
- Read-during-write to the same index returns the old word. This cannot affect fetch because PC is frozen while loading.
- No combinational path from any input to any output except o_pc, which is driven directly from the PC register.

Optional Feature:
- Macro: IF_HALT_DETECT_EN.
- Defined:
  - A fetched word equal to 32'hFFFFFFFF registers into IF/ID normally, valid=1.
  - At that same edge o_halted goes 1 and PC is not advanced.
  - Every later edge: PC holds and IF/ID <= NOP with valid=0.
  - i_stall, i_jump, i_flush and i_load_en do not clear the halt; only rst clears it.
  - i_load_en still writes memory while halted.
- Undefined: 32'hFFFFFFFF is an ordinary instruction and o_halted is tied to 0.

Test Plan:
- Load and run:
  - Stimulus: load mem[0..3] = 0x20010005, 0x20020007, 0x00221820, 0x00000000, then pulse rst.
  - Response: o_instruction on successive cycles is 0x20010005, 0x20020007, 0x00221820; o_pc_plus4 is 4, 8, 12; o_valid=1.
- Stall:
  - Stimulus: i_stall=1 for 2 cycles while o_instruction=0x20020007, o_pc=8.
  - Response: both values held for 2 cycles; 0x00221820 appears on the first edge after release.
- Jump with flush:
  - Stimulus: at o_pc=8, i_jump=1, i_flush=1, i_jump_addr=0x0000000E.
  - Response: next o_instruction=0, o_valid=0, o_pc=0xC; following o_instruction=mem[3].
- Stall overrides jump:
  - Stimulus: i_stall=1, i_jump=1, i_flush=1 in the same cycle.
  - Response: PC and IF/ID unchanged; jump has no effect.
- Wrap-around:
  - Stimulus: MEM_DEPTH=64, PC=0xFC.
  - Response: fetches mem[63]; next PC=0x100 fetches mem[0].
- Halt (IF_HALT_DETECT_EN defined):
  - Stimulus: mem[2]=0xFFFFFFFF.
  - Response: halt word appears with o_valid=1 and o_halted=1 at the same edge; o_pc stays 8; afterwards o_valid=0 until rst.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS IF stage with PC, loadable instruction memory and IF/ID register.
// Define IF_HALT_DETECT_EN to halt fetch on the all-ones instruction word.
module instruction_fetch #(
    parameter int SIZE      = 32,
    parameter int MEM_DEPTH = 64,
    parameter int SIZE_ADDR = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic                 i_jump,
    input  logic [SIZE-1:0]      i_jump_addr,
    input  logic                 i_load_en,
    input  logic [SIZE_ADDR-1:0] i_load_addr,
    input  logic [SIZE-1:0]      i_load_data,
    output logic [SIZE-1:0]      o_instruction,
    output logic [SIZE-1:0]      o_pc_plus4,
    output logic [SIZE-1:0]      o_pc,
    output logic                 o_valid,
    output logic                 o_halted
);
    logic [SIZE-1:0] mem [MEM_DEPTH];
    logic [SIZE-1:0] pc, instruction, pc_plus4, fetch_word, next_pc4, jump_target;
    logic            valid, halted, halt_hit;

    assign fetch_word  = mem[pc[SIZE_ADDR+1:2]];
    assign next_pc4    = pc + SIZE'(4);
    assign jump_target = i_jump_addr & ~SIZE'(3);

`ifdef IF_HALT_DETECT_EN
    assign halt_hit = (fetch_word == '1) && !i_flush;
`else
    assign halt_hit = 1'b0;
`endif

    // Memory is not reset so a program loaded before reset survives it.
    always_ff @(posedge clk) begin
        if (!rst && i_load_en)
            mem[i_load_addr] <= i_load_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            instruction <= '0;
            pc_plus4    <= '0;
            valid       <= 1'b0;
            halted      <= 1'b0;
        end else if (halted) begin
            instruction <= '0;
            pc_plus4    <= '0;
            valid       <= 1'b0;
        end else if (!i_load_en && !i_stall) begin
            // A halt word freezes the PC even if a jump arrives with it.
            pc          <= halt_hit ? pc : (i_jump ? jump_target : next_pc4);
            instruction <= i_flush ? '0 : fetch_word;
            pc_plus4    <= i_flush ? '0 : next_pc4;
            valid       <= !i_flush;
            halted      <= halt_hit;
        end
    end

    assign o_pc          = pc;
    assign o_instruction = instruction;
    assign o_pc_plus4    = pc_plus4;
    assign o_valid       = valid;
    assign o_halted      = halted;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_stall = 1'b0, i_flush = 1'b0, i_jump = 1'b0, i_load_en = 1'b0;
    logic [31:0] i_jump_addr = '0, i_load_data = '0;
    logic [5:0]  i_load_addr = '0;
    logic [31:0] o_instruction, o_pc_plus4, o_pc;
    logic        o_valid, o_halted;
    int          checks = 0, errors = 0;

    instruction_fetch dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush), .i_jump(i_jump),
        .i_jump_addr(i_jump_addr), .i_load_en(i_load_en), .i_load_addr(i_load_addr),
        .i_load_data(i_load_data), .o_instruction(o_instruction), .o_pc_plus4(o_pc_plus4),
        .o_pc(o_pc), .o_valid(o_valid), .o_halted(o_halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_if(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                             input logic [31:0] pc, input logic v, input logic h);
        chk({tag, " instr"}, o_instruction, ins);
        chk({tag, " pc_plus4"}, o_pc_plus4, p4);
        chk({tag, " pc"}, o_pc, pc);
        chk({tag, " valid"}, {31'd0, o_valid}, {31'd0, v});
        chk({tag, " halted"}, {31'd0, o_halted}, {31'd0, h});
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        i_load_en = 1'b1; i_load_addr = a; i_load_data = d;
        tick();
        i_load_en = 1'b0;
    endtask

    initial begin
        tick();
        expect_if("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        load(6'd0, 32'h20010005);
        load(6'd1, 32'h20020007);
        load(6'd2, 32'h00221820);
        load(6'd3, 32'h00000000);
        load(6'd4, 32'h8C010004);
        load(6'd63, 32'h12345678);
        expect_if("load_hold", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); expect_if("run0", 32'h20010005, 32'h4, 32'h4, 1'b1, 1'b0);
        tick(); expect_if("run1", 32'h20020007, 32'h8, 32'h8, 1'b1, 1'b0);
        i_stall = 1'b1;
        tick(); expect_if("stall0", 32'h20020007, 32'h8, 32'h8, 1'b1, 1'b0);
        tick(); expect_if("stall1", 32'h20020007, 32'h8, 32'h8, 1'b1, 1'b0);
        i_stall = 1'b0;
        tick(); expect_if("release", 32'h00221820, 32'hC, 32'hC, 1'b1, 1'b0);
        i_jump = 1'b1; i_jump_addr = 32'hA;
        tick(); expect_if("delay_slot", 32'h0, 32'h10, 32'h8, 1'b1, 1'b0);
        i_flush = 1'b1; i_jump_addr = 32'hE;
        tick(); expect_if("jump_flush", 32'h0, 32'h0, 32'hC, 1'b0, 1'b0);
        i_jump = 1'b0; i_flush = 1'b0;
        tick(); expect_if("after_jump", 32'h0, 32'h10, 32'h10, 1'b1, 1'b0);
        i_stall = 1'b1; i_jump = 1'b1; i_flush = 1'b1; i_jump_addr = 32'h40;
        tick(); expect_if("stall_jump", 32'h0, 32'h10, 32'h10, 1'b1, 1'b0);
        i_stall = 1'b0; i_flush = 1'b0; i_jump_addr = 32'hFC;
        tick(); expect_if("to_fc", 32'h8C010004, 32'h14, 32'hFC, 1'b1, 1'b0);
        i_jump = 1'b0;
        tick(); expect_if("fetch63", 32'h12345678, 32'h100, 32'h100, 1'b1, 1'b0);
        tick(); expect_if("wrap0", 32'h20010005, 32'h104, 32'h104, 1'b1, 1'b0);
        load(6'd1, 32'hAAAA5555);
        expect_if("load_run", 32'h20010005, 32'h104, 32'h104, 1'b1, 1'b0);
        tick(); expect_if("after_load", 32'hAAAA5555, 32'h108, 32'h108, 1'b1, 1'b0);
        i_jump = 1'b1; i_jump_addr = 32'hFFFFFFFF;
        tick(); expect_if("jump_top", 32'h00221820, 32'h10C, 32'hFFFFFFFC, 1'b1, 1'b0);
        i_jump = 1'b0;
        tick(); expect_if("pc_wrap", 32'h12345678, 32'h0, 32'h0, 1'b1, 1'b0);
        rst = 1'b1; i_stall = 1'b1; i_load_en = 1'b1; i_load_addr = 6'd0; i_load_data = 32'hFFFF0000;
        tick(); expect_if("rst_over", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0; i_stall = 1'b0; i_load_en = 1'b0;
        tick(); expect_if("mem_kept", 32'h20010005, 32'h4, 32'h4, 1'b1, 1'b0);
        load(6'd2, 32'hFFFFFFFF);
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); expect_if("h0", 32'h20010005, 32'h4, 32'h4, 1'b1, 1'b0);
        tick(); expect_if("h1", 32'hAAAA5555, 32'h8, 32'h8, 1'b1, 1'b0);
`ifdef IF_HALT_DETECT_EN
        tick(); expect_if("halt", 32'hFFFFFFFF, 32'hC, 32'h8, 1'b1, 1'b1);
        i_jump = 1'b1; i_jump_addr = 32'h0;
        tick(); expect_if("halted", 32'h0, 32'h0, 32'h8, 1'b0, 1'b1);
        i_jump = 1'b0;
        tick(); expect_if("halted2", 32'h0, 32'h0, 32'h8, 1'b0, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        expect_if("halt_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
`else
        tick(); expect_if("ones_word", 32'hFFFFFFFF, 32'hC, 32'hC, 1'b1, 1'b0);
        tick(); expect_if("after_ones", 32'h0, 32'h10, 32'h10, 1'b1, 1'b0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
